// File: rtl/ssd_pkg.sv
// Shared constants and helpers for the seven-segment display scanning logic.
package ssd_pkg;

    localparam int unsigned NIBBLE_W        = 4;
    localparam int unsigned MAX_DIGITS      = 8;
    localparam int unsigned AN_IDX_W        = 3;
    localparam int unsigned DEF_NUM_DIGITS  = 4;
    localparam int unsigned DEF_REFRESH_DIV = 100000;

    // Digit index to active-low one-hot anode enable (widest supported display).
    function automatic logic [MAX_DIGITS-1:0] anode_encode(input logic [AN_IDX_W-1:0] idx);
        return ~(MAX_DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/ssd_prescaler.sv
// Free-running divide-by-DIV counter; tc is high while the count sits at DIV-1.
module ssd_prescaler
    import ssd_pkg::*;
#(
    parameter int unsigned DIV = DEF_REFRESH_DIV
) (
    input  logic clk,
    input  logic rst_n,
    output logic tc
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] pcnt;
    logic [CNT_W-1:0] pcnt_nxt;

    always_comb begin
        pcnt_nxt = pcnt + CNT_W'(1);
        if (tc) begin
            pcnt_nxt = '0;
        end
    end

    // tc is registered from the next count so it tracks pcnt == DIV-1 exactly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcnt <= '0;
            tc   <= 1'b0;
        end else begin
            pcnt <= pcnt_nxt;
            tc   <= (pcnt_nxt == CNT_W'(DIV - 1));
        end
    end

endmodule

// File: rtl/ssd_scan_mux.sv
// Tear-free multiplexed scanner for a common-anode seven-segment display.
// Optional feature: define SSD_LEADING_ZERO_BLANK_EN to blank leading-zero digits.
module ssd_scan_mux
    import ssd_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = DEF_NUM_DIGITS,
    parameter int unsigned REFRESH_DIV = DEF_REFRESH_DIV
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] value_in,
    input  logic                           load,
    output logic [NIBBLE_W-1:0]            dig,
    output logic [NUM_DIGITS-1:0]          an,
    output logic                           frame_done
);

    localparam int unsigned VAL_W = NIBBLE_W * NUM_DIGITS;
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic                  tc;
    logic                  boundary_c;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_nxt;
    logic [VAL_W-1:0]      shadow;
    logic [VAL_W-1:0]      shadow_nxt;
    logic [VAL_W-1:0]      pending;
    logic [VAL_W-1:0]      pending_nxt;
    logic                  pending_v;
    logic                  pending_v_nxt;
    logic [NIBBLE_W-1:0]   dig_nxt;
    logic [NUM_DIGITS-1:0] an_nxt;
    logic [NUM_DIGITS-1:0] blank_c;
    logic [MAX_DIGITS-1:0] an_full;

    ssd_prescaler #(
        .DIV (REFRESH_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tc    (tc)
    );

    // Scan sequencing, capture/shadow handoff and next output values.
    always_comb begin
        boundary_c    = tc && (idx == LAST_IDX);
        idx_nxt       = idx;
        shadow_nxt    = shadow;
        pending_nxt   = pending;
        pending_v_nxt = pending_v;
        dig_nxt       = '0;

        if (tc) begin
            idx_nxt = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
        end

        // A load on the boundary itself bypasses the pending stage.
        if (boundary_c) begin
            if (load) begin
                shadow_nxt = value_in;
            end else if (pending_v) begin
                shadow_nxt = pending;
            end
            pending_v_nxt = 1'b0;
        end else if (load) begin
            pending_nxt   = value_in;
            pending_v_nxt = 1'b1;
        end

        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_nxt == IDX_W'(k)) begin
                dig_nxt = shadow_nxt[k*NIBBLE_W +: NIBBLE_W];
            end
        end

        an_full = anode_encode(AN_IDX_W'(idx_nxt));
        an_nxt  = an_full[NUM_DIGITS-1:0] | blank_c;
    end

    // Leading-zero blank mask; derived from the next shadow so it moves only at frame boundaries.
`ifdef SSD_LEADING_ZERO_BLANK_EN
    logic zero_run;

    always_comb begin
        blank_c  = '0;
        zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            zero_run   = zero_run && (shadow_nxt[k*NIBBLE_W +: NIBBLE_W] == '0);
            blank_c[k] = zero_run;
        end
    end
`else
    always_comb begin
        blank_c = '0;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx        <= '0;
            shadow     <= '0;
            pending    <= '0;
            pending_v  <= 1'b0;
            dig        <= '0;
            an         <= ~(NUM_DIGITS'(1));
            frame_done <= 1'b0;
        end else begin
            idx        <= idx_nxt;
            shadow     <= shadow_nxt;
            pending    <= pending_nxt;
            pending_v  <= pending_v_nxt;
            dig        <= dig_nxt;
            an         <= an_nxt;
            frame_done <= boundary_c;
        end
    end

endmodule

// File: tb/tb_ssd_scan_mux.sv
// Scoreboard bench for ssd_scan_mux with four digits and a four-cycle dwell.
module tb_ssd_scan_mux;

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] dig;
    } slot_t;

`ifdef SSD_LEADING_ZERO_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [15:0] value_in;
    logic        load;
    logic [3:0]  dig;
    logic [3:0]  an;
    logic        frame_done;

    slot_t exp_q[$];
    slot_t cur;
    bit    have_cur;
    bit    started;
    int    k;
    int    n_checks;
    int    n_fail;

    ssd_scan_mux #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value_in   (value_in),
        .load       (load),
        .dig        (dig),
        .an         (an),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at k=%0d: got %h, expected %h", name, k, act, exp);
        end
    endtask

    // Queue one frame (or its first nslots digits); lz marks hand-derived leading-zero digits.
    task automatic push_frame(input logic [15:0] val, input logic [3:0] lz, input int nslots);
        slot_t s;
        for (int d = 0; d < nslots; d++) begin
            s.dig = val[d*4 +: 4];
            s.an  = (BLANK_EN && lz[d]) ? 4'hF : ~(4'b0001 << d);
            exp_q.push_back(s);
        end
    endtask

    task automatic wait_k(input int target);
        int guard;
        guard = 0;
        while (k != target && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (k != target) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_k timeout: k=%0d, expected %0d", k, target);
        end
    endtask

    task automatic pulse_load(input logic [15:0] val);
        value_in = val;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    // Monitor: k counts edges since the last reset edge; each dwell slot pops one expectation.
    initial begin : monitor
        logic r;
        forever begin
            @(posedge clk);
            r = rst_n;
            #1;
            if (!r) begin
                k       = 0;
                started = 1'b1;
            end else if (started) begin
                k++;
            end
            if (started) begin
                if (k % 4 == 0) begin
                    have_cur = (exp_q.size() > 0);
                    if (have_cur) cur = exp_q.pop_front();
                end
                if (have_cur) begin
                    check("an", an, cur.an);
                    check("dig", dig, cur.dig);
                    check("frame_done", {3'b000, frame_done},
                          {3'b000, (k % 16 == 0) && (k != 0)});
                end
            end
        end
    end

    initial begin : stimulus
        n_checks = 0;
        n_fail   = 0;
        k        = 0;
        started  = 1'b0;
        have_cur = 1'b0;
        rst_n    = 1'b0;
        load     = 1'b0;
        value_in = 16'h0000;

        push_frame(16'h0000, 4'b1110, 4);
        push_frame(16'h0000, 4'b1110, 4);
        push_frame(16'h0000, 4'b1110, 4);
        push_frame(16'h1A2F, 4'b0000, 4);
        push_frame(16'h2222, 4'b0000, 4);
        push_frame(16'h0BEE, 4'b1000, 3);

        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        wait_k(37);
        pulse_load(16'h1A2F);
        wait_k(52);
        pulse_load(16'h1111);
        wait_k(56);
        pulse_load(16'h2222);
        wait_k(79);
        pulse_load(16'h0BEE);
        wait_k(85);
        pulse_load(16'h5555);
        wait_k(90);

        // Reset mid-frame with a pending value and a concurrent load that must be ignored.
        push_frame(16'h0000, 4'b1110, 4);
        push_frame(16'h0000, 4'b1110, 4);
        push_frame(16'h0030, 4'b1100, 4);
        push_frame(16'h0000, 4'b1110, 4);
        rst_n    = 1'b0;
        value_in = 16'h7777;
        load     = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        load  = 1'b0;

        wait_k(20);
        pulse_load(16'h0030);
        wait_k(40);
        pulse_load(16'h0000);
        wait_k(63);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
